// File: rtl/data_memory_if.sv
// Load/store bus between the RV32I control path (master) and the data memory (slave).
interface data_memory_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_rw;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        misalign;
    logic [7:0]  led;

    modport master (
        output addr, wdata, mem_rw, funct3,
        input  rdata, misalign, led
    );

    modport slave (
        input  addr, wdata, mem_rw, funct3,
        output rdata, misalign, led
    );
endinterface

// File: rtl/data_memory.sv
// Data memory for the single-cycle RV32I core: byte-lane stores, extended combinational loads,
// sticky misalign flag. Define DMEM_MMIO_EN to add the cycle counter / LED MMIO window.
module data_memory #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] word_idx;
    logic              is_store;
    logic              is_half;
    logic              is_word;
    logic              misaligned;
    logic              mmio_hit;
    logic              store_ok;
    logic [3:0]        lane_we;
    logic [31:0]       wdata_rep;
    logic [31:0]       ram_word;
    logic [31:0]       src_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic              misalign_q;
    logic              misalign_d;
    logic              unused_bits;

    assign word_idx = bus.addr[ADDR_W+1:2];

    always_comb begin
        is_store   = bus.mem_rw && (bus.funct3 == 3'b000 || bus.funct3 == 3'b001 ||
                                    bus.funct3 == 3'b010);
        // LHU (101) only exists as a load; as a store it is a no-op, not a half access
        is_half    = (bus.funct3 == 3'b001) || (!bus.mem_rw && bus.funct3 == 3'b101);
        is_word    = (bus.funct3 == 3'b010);
        misaligned = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
        store_ok   = is_store && !misaligned && !mmio_hit;
    end

    always_comb begin
        lane_we   = 4'b0000;
        wdata_rep = bus.wdata;
        case (bus.funct3)
            3'b000: begin
                lane_we   = 4'b0001 << bus.addr[1:0];
                wdata_rep = {4{bus.wdata[7:0]}};
            end
            3'b001: begin
                lane_we   = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.wdata[15:0]}};
            end
            3'b010:  lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
        if (!store_ok) begin
            lane_we = 4'b0000;
        end
    end

    // One byte-wide array per lane so partial stores never read-modify-write.
    // Writes in a cycle with rst_n low are dropped; contents survive reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (rst_n && lane_we[gi]) begin
                    lane_mem[word_idx] <= wdata_rep[8*gi +: 8];
                end
            end

            assign ram_word[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

`ifdef DMEM_MMIO_EN
    logic [63:0] cnt_q;
    logic [7:0]  led_q;
    logic [7:0]  led_d;
    logic [31:0] mmio_word;

    assign mmio_hit = (bus.addr[31:4] == MMIO_BASE[31:4]);

    always_comb begin
        led_d = led_q;
        if (bus.mem_rw && mmio_hit && bus.addr[3:0] == 4'h8 &&
            (bus.funct3 == 3'b000 || bus.funct3 == 3'b010)) begin
            led_d = bus.wdata[7:0];
        end
    end

    always_comb begin
        case (bus.addr[3:2])
            2'd0:    mmio_word = cnt_q[31:0];
            2'd1:    mmio_word = cnt_q[63:32];
            2'd2:    mmio_word = {24'b0, led_q};
            default: mmio_word = 32'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 64'd0;
            led_q <= 8'd0;
        end else begin
            cnt_q <= cnt_q + 64'd1;
            led_q <= led_d;
        end
    end

    assign bus.led  = led_q;
    assign src_word = mmio_hit ? mmio_word : ram_word;
`else
    assign mmio_hit = 1'b0;
    assign bus.led  = 8'd0;
    assign src_word = ram_word;
`endif

    assign sel_byte = src_word[{bus.addr[1:0], 3'b000} +: 8];
    assign sel_half = bus.addr[1] ? src_word[31:16] : src_word[15:0];

    // Lane selection first, then extension
    always_comb begin
        bus.rdata = 32'd0;
        if (!misaligned) begin
            case (bus.funct3)
                3'b000:  bus.rdata = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  bus.rdata = {{16{sel_half[15]}}, sel_half};
                3'b010:  bus.rdata = src_word;
                3'b100:  bus.rdata = {24'd0, sel_byte};
                3'b101:  bus.rdata = {16'd0, sel_half};
                default: bus.rdata = 32'd0;
            endcase
        end
    end

    assign misalign_d = misalign_q | misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.misalign = misalign_q;

    // High address bits alias the RAM; the base only matters with the MMIO window
    assign unused_bits = ^{MMIO_BASE, bus.addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: lane stores, extended loads, aliasing, misalign, reset, MMIO/LED.
module tb_data_memory;

    localparam int          ADDR_W    = 10;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    data_memory_if bus();

    data_memory #(
        .ADDR_W    (ADDR_W),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus.mem_rw = rw;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = d;
    endtask

    task automatic idle();
        drive(1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, f3, a, d);
        cyc();
        idle();
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, f3, a, 32'h0);
        #1;
        check(tag, bus.rdata, exp);
        cyc();
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        check("rst_led", {24'd0, bus.led}, 32'd0);
        cyc();
        rst_n = 1'b1;

        // word store then every load flavour on its lanes
        store(3'b010, 32'h10, 32'h8899_AABB);
        load_chk("lw_10",   3'b010, 32'h10, 32'h8899_AABB);
        load_chk("lb_10",   3'b000, 32'h10, 32'hFFFF_FFBB);
        load_chk("lbu_11",  3'b100, 32'h11, 32'h0000_00AA);
        load_chk("lh_12",   3'b001, 32'h12, 32'hFFFF_8899);
        load_chk("lhu_12",  3'b101, 32'h12, 32'h0000_8899);
        load_chk("lb_13",   3'b000, 32'h13, 32'hFFFF_FF88);
        load_chk("lh_10",   3'b001, 32'h10, 32'hFFFF_AABB);
        load_chk("f3_011",  3'b011, 32'h10, 32'h0000_0000);

        store(3'b000, 32'h13, 32'h1234_5655);
        load_chk("sb_13",   3'b010, 32'h10, 32'h5599_AABB);

        store(3'b010, 32'h14, 32'h0000_0000);
        store(3'b001, 32'h16, 32'h7777_BEEF);
        load_chk("sh_16",   3'b010, 32'h14, 32'hBEEF_0000);

        store(3'b011, 32'h14, 32'hFFFF_FFFF);
        load_chk("st_f3_011", 3'b010, 32'h14, 32'hBEEF_0000);

        // same-cycle read of the address being written shows the old word
        store(3'b010, 32'h20, 32'hCAFE_F00D);
        drive(1'b1, 3'b010, 32'h20, 32'h1111_2222);
        #1;
        check("rd_during_wr", bus.rdata, 32'hCAFE_F00D);
        cyc();
        idle();
        load_chk("wr_visible", 3'b010, 32'h20, 32'h1111_2222);

        store(3'b010, 32'h10 + 32'(4 << ADDR_W), 32'h0BAD_BEEF);
        load_chk("alias", 3'b010, 32'h10, 32'h0BAD_BEEF);

        // misaligned word store: suppressed, rdata 0, sticky flag
        check("mis_before", {31'd0, bus.misalign}, 32'd0);
        drive(1'b1, 3'b010, 32'h22, 32'hDEAD_DEAD);
        #1;
        check("mis_rdata", bus.rdata, 32'd0);
        check("mis_not_yet", {31'd0, bus.misalign}, 32'd0);
        cyc();
        idle();
        check("mis_set", {31'd0, bus.misalign}, 32'd1);
        load_chk("mis_no_wr", 3'b010, 32'h20, 32'h1111_2222);
        repeat (5) cyc();
        check("mis_sticky", {31'd0, bus.misalign}, 32'd1);

        // LED register (aliases into RAM when the window is not built)
        store(3'b010, 32'hF08, 32'h1357_9BDF);
        store(3'b000, MMIO_BASE + 32'h8, 32'h0000_00A5);
`ifdef DMEM_MMIO_EN
        check("led_set", {24'd0, bus.led}, 32'h0000_00A5);
        load_chk("led_rd", 3'b010, MMIO_BASE + 32'h8, 32'h0000_00A5);
        load_chk("led_ram_keep", 3'b010, 32'hF08, 32'h1357_9BDF);
`else
        check("led_zero", {24'd0, bus.led}, 32'h0);
        load_chk("led_alias", 3'b010, 32'hF08, 32'h1357_9BA5);
`endif

        // asynchronous reset mid-run; a store under reset is dropped
        store(3'b010, 32'h30, 32'h0102_0304);
        drive(1'b1, 3'b010, 32'h30, 32'h7777_7777);
        rst_n = 1'b0;
        #1;
        check("arst_misalign", {31'd0, bus.misalign}, 32'd0);
        check("arst_led", {24'd0, bus.led}, 32'd0);
        cyc();
        idle();
        rst_n = 1'b1;
        load_chk("arst_no_wr", 3'b010, 32'h30, 32'h0102_0304);

`ifdef DMEM_MMIO_EN
        // load_chk above consumed one edge since reset release
        repeat (99) cyc();
        load_chk("cnt_lo", 3'b010, MMIO_BASE, 32'd100);
        load_chk("cnt_hi", 3'b010, MMIO_BASE + 32'h4, 32'd0);
        store(3'b010, MMIO_BASE, 32'hFFFF_FFFF);
        load_chk("cnt_ro", 3'b010, MMIO_BASE, 32'd103);
`endif

        load_chk("lh_odd", 3'b001, 32'h11, 32'd0);
        check("mis_again", {31'd0, bus.misalign}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Data-side memory responder for the single-cycle RV32I core. It serves the load/store requests issued by the control path: write enable from `mem_rw`, access size from `funct3`, address from the ALU result and store data from rs2. It performs byte-lane writes and sign/zero-extended reads, and flags misaligned accesses. An optional memory-mapped cycle counter and LED register are included.

## Interface
Parameters:
- `ADDR_W`, 10: log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- `MMIO_BASE`, 32'hFFFF_FF00: base address of the MMIO window (used only with `DMEM_MMIO_EN`).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2), right-aligned.
- `mem_rw`  in  1  `MEM_READ`=0, `MEM_WRITE`=1.
- `funct3`  in  3  inst[14:12]; selects access size and extension.
- `rdata`  out  32  load result, already extended; feeds the `WB_DMEM` writeback path.
- `misalign`  out  1  sticky misaligned-access error.
- `led`  out  8  LED register (MMIO).

## Operation
- RAM: 2^ADDR_W × 32-bit words, indexed by `addr[ADDR_W+1:2]`. Higher address bits are ignored, so the RAM aliases across the address space. RAM contents are not reset.
- Loads (`mem_rw`=0) are combinational from `addr` and `funct3`:
  - 000 LB: byte `addr[1:0]`, sign-extended.
  - 001 LH: half `addr[1]`, sign-extended.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extended.
  - 011/110/111: `rdata`=0.
- `rdata` is also driven during stores (same decode). It is ignored by writeback.
- Stores (`mem_rw`=1): 000 SB writes `wdata[7:0]` to byte lane `addr[1:0]`; 001 SH writes `wdata[15:0]` to half `addr[1]`; 010 SW writes the full word. Other funct3 values: no write. Unselected lanes are untouched.
- Misaligned access:
  - Condition: half access with `addr[0]`=1, or word access with `addr[1:0]`≠0, on either read or write.
  - The store is suppressed and `rdata`=0.
  - `misalign` is set at the next rising edge and stays set until reset.
- Extension is applied after lane selection. Byte 0x80 gives LB=0xFFFF_FF80, LBU=0x0000_0080.

## Timing
- Read latency 0 (combinational, single-cycle core).
- Write commits on the rising edge and is visible to a read in the following cycle. A read of the written address in the same cycle returns the old data.
- Reset values: `misalign`=0, `led`=0, cycle counter=0. `rdata` follows its inputs; with the RAM uninitialised, the bench must store before it loads.
- Reset asserted mid-operation clears the flag, counter and LED immediately. A store in a cycle in which `rst_n` is low is dropped. RAM keeps its contents.
- `misalign` setting and a valid store in the same cycle are mutually exclusive by definition (a misaligned store never writes).

## Configuration
- `DMEM_MMIO_EN` defined:
  - Word accesses to `MMIO_BASE`+0x0 and +0x4 read the low and high halves of a 64-bit free-running cycle counter. The counter increments every cycle after reset and reads return the pre-increment value. Writes to these addresses are ignored.
  - `MMIO_BASE`+0x8: SW/SB sets `led` from `wdata[7:0]`; reads return {24'b0, `led`}.
  - Sub-word reads in the window use the same lane/extension rules.
  - MMIO accesses never touch the RAM.
- Undefined: no counter or LED logic is built. `led` is tied to 0 and the MMIO addresses alias into the RAM like any other address.

## Test plan
- SW 0x8899_AABB @0x10, then LW/LB/LBU/LH/LHU @0x10,0x11,0x12: 0x8899_AABB, 0xFFFF_FFBB@0x10, 0x0000_00AA@0x11 (LBU), 0xFFFF_8899@0x12 (LH), 0x0000_8899 (LHU).
- SB 0x55 @0x13 over that word, then LW @0x10 → 0x5599_AABB; other lanes unchanged.
- SW @0x22 → no write (LW @0x20 unchanged); `misalign` 0→1 the next cycle and stays 1 until `rst_n` pulses low.
- Store @addr 0x10 + 4·2^ADDR_W, then LW @0x10 → same data (aliasing). Also: same-cycle read of the written address returns the old data.
- With `DMEM_MMIO_EN`: release reset, wait 100 cycles, LW `MMIO_BASE` → 100 (±design-fixed offset checked against a bench counter). Then SB 0xA5 @`MMIO_BASE`+8 → `led`=0xA5 next cycle and RAM untouched. Without the macro: `led` stays 0.
- Assert `rst_n` low mid-run → `misalign`, `led`, counter 0 asynchronously; a store issued during reset is not committed.
